// File: rtl/sopc_pkg.sv
// sopc_pkg: shared definitions for the MIPS SOPC run-control logic.
//   rc_state_t   - run-control FSM states
//   STATUS_*     - encodings driven on sopc_run_ctrl.status
//   DEF_PC_W/DEF_LED_W - default core PC and LED display widths
package sopc_pkg;

  typedef enum logic [2:0] {
    RC_RST  = 3'd0,
    RC_RUN  = 3'd1,
    RC_HALT = 3'd2,
    RC_STEP = 3'd3,
    RC_TMO  = 3'd4
  } rc_state_t;

  localparam logic [1:0] STATUS_RESET = 2'd0;
  localparam logic [1:0] STATUS_RUN   = 2'd1;
  localparam logic [1:0] STATUS_HALT  = 2'd2;
  localparam logic [1:0] STATUS_TMO   = 2'd3;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_LED_W = 16;

endpackage

// File: rtl/sopc_run_ctrl_rst_sync.sv
// rst_sync: asynchronous-assert, synchronous-release reset synchroniser.
//   clk        - destination clock
//   rst_n      - raw active-low reset (asynchronous)
//   rst_n_sync - active-low reset, released two clk edges after rst_n rises
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_n_sync <= meta;
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run control for the MIPS SOPC core.
// Generates a synchronised, stretched core reset and a core clock enable,
// counts enabled cycles, halts on a PC breakpoint or cycle budget, supports
// single-step / resume from HALT and drives the PC LED display.
//   clk_init/rst_init    - board clock and async active-low reset
//   pc_in/pc_valid       - current core PC and its qualifier
//   brk_en/brk_pc        - breakpoint enable and address
//   run_req/step_req     - resume / single-step pulses (honoured in HALT)
//   cpu_rst/cpu_ce       - core reset (active high) and clock enable
//   led_pc               - pc_in[LED_W+1:2] of last enabled valid PC
//   cycle_cnt            - saturating count of cpu_ce-high cycles
//   halted/status        - HALT/TMO flag and 2-bit state code
module sopc_run_ctrl
  import sopc_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int LED_W      = DEF_LED_W,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 50
) (
  input  logic             clk_init,
  input  logic             rst_init,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_valid,
  input  logic             brk_en,
  input  logic [PC_W-1:0]  brk_pc,
  input  logic             run_req,
  input  logic             step_req,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic [LED_W-1:0] led_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             halted,
  output logic [1:0]       status
);

  localparam int              HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rc_state_t         state, state_nxt;
  logic              rel;
  logic [HOLD_W-1:0] hold_cnt;
  logic              brk_mask;
  logic              budget_hit;
  logic              brk_hit;

  rst_sync u_rst_sync (
    .clk        (clk_init),
    .rst_n      (rst_init),
    .rst_n_sync (rel)
  );

  assign budget_hit = (MAX_CYCLES != 0) && (cycle_cnt == BUDGET_LAST);
  assign brk_hit    = brk_en && pc_valid && (pc_in == brk_pc);

  assign cpu_rst = (state == RC_RST);
  assign cpu_ce  = (state == RC_RUN) || (state == RC_STEP);
  assign halted  = (state == RC_HALT) || (state == RC_TMO);

  always_comb begin
    status = STATUS_RESET;
    case (state)
      RC_RUN:           status = STATUS_RUN;
      RC_HALT, RC_STEP: status = STATUS_HALT;
      RC_TMO:           status = STATUS_TMO;
      default:          status = STATUS_RESET;
    endcase
  end

  // Budget is tested before the breakpoint so a match on the last budgeted
  // cycle still ends in TMO. brk_mask suppresses the compare on the first
  // RUN cycle after HALT so resuming on the breakpoint PC makes progress.
  always_comb begin
    state_nxt = state;
    case (state)
      RC_RST:  if (rel && hold_cnt == HOLD_LAST) state_nxt = RC_RUN;
      RC_RUN: begin
        if (budget_hit)             state_nxt = RC_TMO;
        else if (brk_hit && !brk_mask) state_nxt = RC_HALT;
      end
      RC_HALT: begin
        if (run_req)       state_nxt = RC_RUN;
        else if (step_req) state_nxt = RC_STEP;
      end
      RC_STEP: state_nxt = budget_hit ? RC_TMO : RC_HALT;
      RC_TMO:  state_nxt = RC_TMO;
      default: state_nxt = RC_RST;
    endcase
  end

  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      state    <= RC_RST;
      hold_cnt <= '0;
      brk_mask <= 1'b0;
    end else begin
      state    <= state_nxt;
      brk_mask <= (state == RC_HALT) && (state_nxt == RC_RUN);
      if (state == RC_RST && rel && hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      cycle_cnt <= '0;
      led_pc    <= '0;
    end else if (cpu_ce) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (pc_valid) led_pc <= pc_in[LED_W+1:2];
    end
  end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl: directed scenarios with literal expectations followed by
// randomized stimulus, all outputs compared every cycle against a behavioural
// model built from counters and flags.
module tb_sopc_run_ctrl;

  localparam int PC_W       = 32;
  localparam int LED_W      = 16;
  localparam int RST_HOLD   = 4;
  localparam int CNT_W      = 32;
  localparam int MAX_CYCLES = 50;

  logic             clk_init = 1'b0;
  logic             rst_init;
  logic [PC_W-1:0]  pc_in    = '0;
  logic             pc_valid = 1'b0;
  logic             brk_en   = 1'b0;
  logic [PC_W-1:0]  brk_pc   = '0;
  logic             run_req  = 1'b0;
  logic             step_req = 1'b0;
  logic             cpu_rst;
  logic             cpu_ce;
  logic [LED_W-1:0] led_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic             halted;
  logic [1:0]       status;

  int n_checks = 0;
  int n_err    = 0;

  sopc_run_ctrl #(
    .PC_W(PC_W), .LED_W(LED_W), .RST_HOLD(RST_HOLD),
    .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk_init (clk_init), .rst_init (rst_init),
    .pc_in    (pc_in),    .pc_valid (pc_valid),
    .brk_en   (brk_en),   .brk_pc   (brk_pc),
    .run_req  (run_req),  .step_req (step_req),
    .cpu_rst  (cpu_rst),  .cpu_ce   (cpu_ce),
    .led_pc   (led_pc),   .cycle_cnt(cycle_cnt),
    .halted   (halted),   .status   (status)
  );

  always #5 clk_init = ~clk_init;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_since : rising edges seen with rst_init high since the last reset
  // m_ce_count : total enabled cycles; m_paused : core stopped by breakpoint
  // m_step : a single-step cycle is in progress; m_mask : next run cycle
  // ignores the breakpoint
  int      m_since    = 0;
  longint  m_ce_count = 0;
  int      m_led      = 0;
  bit      m_paused   = 0;
  bit      m_step     = 0;
  bit      m_mask     = 0;

  function automatic bit m_in_reset();
    return m_since < 2 + RST_HOLD;
  endfunction
  function automatic bit m_timed();
    return (MAX_CYCLES != 0) && (m_ce_count >= MAX_CYCLES);
  endfunction
  function automatic bit m_ce();
    return !m_in_reset() && !m_timed() && (!m_paused || m_step);
  endfunction

  always @(posedge clk_init) begin
    bit ce;
    bit running;
    if (!rst_init) begin
      m_since = 0; m_ce_count = 0; m_led = 0;
      m_paused = 0; m_step = 0; m_mask = 0;
    end else if (m_in_reset()) begin
      m_since++;
    end else begin
      ce      = m_ce();
      running = ce && !m_step;
      if (ce) begin
        m_ce_count++;
        if (pc_valid) m_led = int'((pc_in >> 2) & 32'hFFFF);
      end
      if (running) begin
        if (!m_timed() && brk_en && pc_valid && pc_in == brk_pc && !m_mask)
          m_paused = 1;
        m_mask = 0;
      end else if (m_step) begin
        m_step = 0;
      end else if (m_paused && !m_timed()) begin
        if (run_req) begin
          m_paused = 0;
          m_mask   = 1;
        end else if (step_req) begin
          m_step = 1;
        end
      end
    end
  end

  // Every cycle: compare all outputs against the model.
  always @(negedge clk_init) begin
    logic [1:0] e_status;
    logic       e_rst, e_ce, e_halted;
    longint     e_cnt;
    int         e_led;
    e_rst    = m_in_reset();
    e_ce     = m_ce();
    e_halted = !m_in_reset() && (m_timed() || (m_paused && !m_step));
    e_cnt    = m_ce_count;
    e_led    = m_led;
    if (m_in_reset())    e_status = 2'd0;
    else if (m_timed())  e_status = 2'd3;
    else if (m_paused)   e_status = 2'd2;
    else                 e_status = 2'd1;
    if (!rst_init) begin
      e_rst = 1; e_ce = 0; e_halted = 0; e_cnt = 0; e_led = 0; e_status = 2'd0;
    end
    chk("m_cpu_rst",   64'(cpu_rst),   64'(e_rst));
    chk("m_cpu_ce",    64'(cpu_ce),    64'(e_ce));
    chk("m_halted",    64'(halted),    64'(e_halted));
    chk("m_status",    64'(status),    64'(e_status));
    chk("m_cycle_cnt", 64'(cycle_cnt), 64'(e_cnt));
    chk("m_led_pc",    64'(led_pc),    64'(e_led));
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int rst_hold_cycles;
    rst_init = 1'b1;
    #1 rst_init = 1'b0;
    brk_en = 1; brk_pc = 32'h10; pc_valid = 1; pc_in = 32'h0;
    repeat (3) @(posedge clk_init);
    #1;
    chk("rst_cpu_rst", 64'(cpu_rst), 1);
    chk("rst_cpu_ce", 64'(cpu_ce), 0);
    chk("rst_led", 64'(led_pc), 0);
    chk("rst_cnt", 64'(cycle_cnt), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_status", 64'(status), 0);

    // Release: cpu_rst must fall on the 6th edge sampling rst_init high.
    rst_init = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk_init); #1;
      chk("rel_hold_rst", 64'(cpu_rst), 1);
      chk("rel_hold_status", 64'(status), 0);
    end
    @(posedge clk_init); #1;
    chk("rel_cpu_rst", 64'(cpu_rst), 0);
    chk("rel_cpu_ce", 64'(cpu_ce), 1);
    chk("rel_status", 64'(status), 1);

    // Breakpoint at 0x10 with PC stepping by 4 from 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_init); #1;
      pc_in = pc_in + 32'd4;
    end
    @(posedge clk_init); #1;
    chk("brk_halted", 64'(halted), 1);
    chk("brk_status", 64'(status), 2);
    chk("brk_ce", 64'(cpu_ce), 0);
    chk("brk_cnt", 64'(cycle_cnt), 5);
    chk("brk_led", 64'(led_pc), 4);

    // Single step.
    step_req = 1;
    @(posedge clk_init); #1;
    step_req = 0;
    chk("step_ce", 64'(cpu_ce), 1);
    chk("step_status", 64'(status), 2);
    @(posedge clk_init); #1;
    chk("step_back_ce", 64'(cpu_ce), 0);
    chk("step_back_halted", 64'(halted), 1);
    chk("step_cnt", 64'(cycle_cnt), 6);

    // Resume on the breakpoint PC: no re-halt on the first run cycle.
    run_req = 1;
    @(posedge clk_init); #1;
    run_req = 0;
    chk("resume_status", 64'(status), 1);
    @(posedge clk_init); #1;
    chk("resume_no_rehalt", 64'(status), 1);
    @(posedge clk_init); #1;
    chk("resume_rehalt", 64'(status), 2);
    chk("resume_cnt", 64'(cycle_cnt), 8);

    // Simultaneous run+step resolves to RUN.
    run_req = 1; step_req = 1; pc_in = 32'h100;
    @(posedge clk_init); #1;
    run_req = 0; step_req = 0;
    chk("both_req_status", 64'(status), 1);

    // Run to the last budgeted cycle, then present the breakpoint PC.
    guard = 0;
    while (cycle_cnt != 49 && guard < 100) begin
      @(posedge clk_init); #1;
      guard++;
    end
    chk("budget_reach_49", 64'(cycle_cnt), 49);
    chk("budget_pre_status", 64'(status), 1);
    pc_in = 32'h10;
    @(posedge clk_init); #1;
    chk("tmo_status", 64'(status), 3);
    chk("tmo_halted", 64'(halted), 1);
    chk("tmo_ce", 64'(cpu_ce), 0);
    chk("tmo_cnt", 64'(cycle_cnt), 50);
    run_req = 1;
    @(posedge clk_init); #1;
    run_req = 0; step_req = 1;
    @(posedge clk_init); #1;
    step_req = 0;
    @(posedge clk_init); #1;
    chk("tmo_sticky_status", 64'(status), 3);
    chk("tmo_sticky_cnt", 64'(cycle_cnt), 50);

    // Reset mid-run takes effect without a clock edge.
    rst_init = 0; pc_in = 32'h100;
    repeat (2) @(posedge clk_init);
    #1 rst_init = 1;
    repeat (10) @(posedge clk_init);
    #1;
    chk("midrun_running", 64'(status), 1);
    @(posedge clk_init);
    #3 rst_init = 0;
    #1;
    chk("midrun_cpu_rst", 64'(cpu_rst), 1);
    chk("midrun_ce", 64'(cpu_ce), 0);
    chk("midrun_cnt", 64'(cycle_cnt), 0);
    chk("midrun_status", 64'(status), 0);
    @(posedge clk_init);
    #1 rst_init = 1;

    // Randomized phase.
    rst_hold_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_init); #1;
      if (rst_hold_cycles > 0) begin
        rst_hold_cycles--;
        rst_init = (rst_hold_cycles == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        rst_init = 0;
        rst_hold_cycles = 2;
      end
      pc_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: pc_in = 32'h0;
        1: pc_in = 32'h4;
        2: pc_in = 32'h8;
        3: pc_in = 32'h10;
        4: pc_in = 32'h100;
        default: pc_in = $urandom;
      endcase
      brk_en = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0: brk_pc = 32'h10;
        1: brk_pc = 32'h8;
        default: brk_pc = 32'h100;
      endcase
      run_req  = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 6) == 0);
    end
    run_req = 0; step_req = 0;
    @(posedge clk_init); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
